fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch stage: PC register, sequential next-PC, redirect
//  (branch/jump) handling and a DEPTH-entry instruction queue with valid/ready

---
 rtl/fetch_queue_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//
// Purpose:
//   Instruction-fetch stage. Holds the PC, addresses a combinational
//   instruction ROM, and pushes {pc, instruction} pairs into a DEPTH-entry
//   show-ahead queue that feeds decode with a valid/ready handshake.
//   A redirect (branch/jump) flushes the queue and reloads the PC.
//   The queue decouples decode stalls from fetch.
//
// Parameters:
//   WIDTH    - address/instruction width in bits
//   DEPTH    - queue entries (power of two, >= 2)
//   RESET_PC - PC value loaded on reset
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous reset, active-low (0 = reset)
//   redirect_valid in   take redirect_pc this cycle
//   redirect_pc    in   redirect target, bits [1:0] forced to zero
//   imem_addr      out  ROM address (always the current PC)
//   imem_rdata     in   ROM data for imem_addr, same cycle
//   out_valid      out  queue head valid
//   out_ready      in   decode accepts the head
//   out_instr      out  head instruction (0 when empty)
//   out_pc         out  head PC (0 when empty)
//   perf_fetched   out  [FETCH_PERF_EN] saturating count of pushes
//   perf_flushed   out  [FETCH_PERF_EN] saturating count of flushed entries
//
// Build option:
//   FETCH_PERF_EN  - when defined, adds the two performance counters.
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushed
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] pcMem_q    [DEPTH];
  logic [WIDTH-1:0] instrMem_q [DEPTH];

  logic queueValid;
  logic pop;
  logic push;

  // A full queue can still accept a push when the head leaves in the same
  // cycle, so fetch never inserts a bubble behind a draining decode.
  assign queueValid = (count_q != '0);
  assign pop        = queueValid & out_ready;
  assign push       = ~redirect_valid & ((count_q < CW'(DEPTH)) | pop);

  assign imem_addr  = pc_q;
  assign out_valid  = queueValid;
  assign out_instr  = queueValid ? instrMem_q[rdPtr_q] : '0;
  assign out_pc     = queueValid ? pcMem_q[rdPtr_q]    : '0;

  // Next-state: redirect dominates and empties the queue; otherwise the
  // pointers and count track push/pop independently.
  always_comb begin
    pc_d    = pc_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[WIDTH-1:2], 2'b00};
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d    = pc_q + WIDTH'(4);
        wrPtr_d = wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Queue storage needs no reset: every read is gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem_q[wrPtr_q]    <= pc_q;
      instrMem_q[wrPtr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched_q, perfFetched_d;
  logic [31:0] perfFlushed_q, perfFlushed_d;
  logic [32:0] flushSum;

  // The entry popped during a redirect reached decode, so it is excluded
  // from the flushed tally. Both counters saturate instead of wrapping.
  always_comb begin
    flushSum      = {1'b0, perfFlushed_q} + 33'(count_q - CW'(pop));
    perfFetched_d = perfFetched_q;
    perfFlushed_d = perfFlushed_q;
    if (push && (perfFetched_q != '1)) begin
      perfFetched_d = perfFetched_q + 32'd1;
    end
    if (redirect_valid) begin
      perfFlushed_d = flushSum[32] ? '1 : flushSum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfFetched_q <= '0;
      perfFlushed_q <= '0;
    end else begin
      perfFetched_q <= perfFetched_d;
      perfFlushed_q <= perfFlushed_d;
    end
  end

  assign perf_fetched = perfFetched_q;
  assign perf_flushed = perfFlushed_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_unit
//
// Directed self-checking bench for fetch_queue_unit. Two instances share the
// clock and reset: dut runs with RESET_PC=0 and is driven through the main
// scenarios; dutHi starts at 0xFFFF_FFF8 with decode always ready so the PC
// wrap-around can be observed. The ROM returns (addr>>2)*0x11.
// ---------------------------------------------------------------------------
module tb_fetch_queue_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic [31:0] hiAddr;
  logic [31:0] hiRdata;
  logic        hiValid;
  logic [31:0] hiInstr;
  logic [31:0] hiPc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] hiPerfFetched;
  logic [31:0] hiPerfFlushed;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int expFetched = 0;

  function automatic logic [31:0] romWord(input logic [31:0] addr);
    return (addr >> 2) * 32'h11;
  endfunction

  assign imem_rdata = romWord(imem_addr);
  assign hiRdata    = romWord(hiAddr);

  fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  fetch_queue_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutHi (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_addr      (hiAddr),
    .imem_rdata     (hiRdata),
    .out_valid      (hiValid),
    .out_ready      (1'b1),
    .out_instr      (hiInstr),
    .out_pc         (hiPc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (hiPerfFetched),
    .perf_flushed   (hiPerfFlushed)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, then samples 1 time unit after the edge.
  task automatic applyStimulus(input logic redir, input logic [31:0] target,
                               input logic ready);
    redirect_valid = redir;
    redirect_pc    = target;
    out_ready      = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_pc",    out_pc,    32'h0);
    checkOutput("rst_instr", out_instr, 32'h0);
    checkOutput("rst_addr",  imem_addr, 32'h0);
    checkOutput("rst_hiaddr", hiAddr,   32'hFFFF_FFF8);
`ifdef FETCH_PERF_EN
    checkOutput("rst_fetched", perf_fetched, 32'h0);
    checkOutput("rst_flushed", perf_flushed, 32'h0);
`endif
    rst = 1'b1;

    // Streaming with decode ready; dutHi shows the PC wrap.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      expFetched++;
      checkOutput("stream_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("stream_pc",    out_pc,    32'(4 * k));
      checkOutput("stream_instr", out_instr, 32'(k * 32'h11));
      checkOutput("wrap_pc",      hiPc,      32'hFFFF_FFF8 + 32'(4 * k));
      checkOutput("wrap_instr",   hiInstr,   romWord(32'hFFFF_FFF8 + 32'(4 * k)));
    end

    // Decode stalled for 8 cycles: head 0xC stays, queue fills to 4.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      if (k < 3) expFetched++;
      checkOutput("stall_valid", {31'b0, out_valid}, 32'h1);
      checkOutput("stall_pc",    out_pc,    32'h0000_000C);
      checkOutput("stall_instr", out_instr, 32'h0000_0033);
    end
    checkOutput("stall_hold_addr", imem_addr, 32'h0000_001C);

    // Release: full queue drains in order while refilling every cycle.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      expFetched++;
      checkOutput("drain_pc",    out_pc,    32'h0000_000C + 32'(4 * k));
      checkOutput("drain_instr", out_instr, romWord(32'h0000_000C + 32'(4 * k)));
      checkOutput("drain_full",  imem_addr, 32'h0000_001C + 32'(4 * k));
    end

    // Redirect from a full queue while decode takes the head: 3 flushed.
    applyStimulus(1'b1, 32'h0000_0200, 1'b1);
    checkOutput("redir1_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("redir1_addr",  imem_addr, 32'h0000_0200);
    checkOutput("redir1_pc",    out_pc,    32'h0);

    // Build up 3 entries at the new target.
    applyStimulus(1'b0, 32'h0, 1'b0);
    expFetched++;
    checkOutput("target_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("target_pc",    out_pc,    32'h0000_0200);
    checkOutput("target_instr", out_instr, 32'h0000_0880);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    expFetched += 2;
    checkOutput("fill3_addr", imem_addr, 32'h0000_020C);

    // Redirect with 3 queued, low address bits ignored.
    applyStimulus(1'b1, 32'h0000_0103, 1'b0);
    checkOutput("redir2_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("redir2_addr",  imem_addr, 32'h0000_0100);
    applyStimulus(1'b0, 32'h0, 1'b0);
    expFetched++;
    checkOutput("redir2_head_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("redir2_head_pc",    out_pc,    32'h0000_0100);
    checkOutput("redir2_head_instr", out_instr, 32'h0000_0440);
`ifdef FETCH_PERF_EN
    checkOutput("perf_flushed_a", perf_flushed, 32'd6);
`endif

    // Back-to-back redirects: the last target wins.
    applyStimulus(1'b1, 32'h0000_0300, 1'b1);
    applyStimulus(1'b1, 32'h0000_0502, 1'b1);
    checkOutput("b2b_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("b2b_addr",  imem_addr, 32'h0000_0500);
    applyStimulus(1'b0, 32'h0, 1'b1);
    expFetched++;
    checkOutput("b2b_pc",    out_pc,    32'h0000_0500);
    checkOutput("b2b_instr", out_instr, 32'h0000_1540);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", perf_fetched, 32'(expFetched));
    checkOutput("perf_flushed_b", perf_flushed, 32'd6);
`endif

    // Reset asserted between edges clears outputs at once.
    #3;
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("midrst_pc",    out_pc,    32'h0);
    checkOutput("midrst_instr", out_instr, 32'h0);
    checkOutput("midrst_addr",  imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    checkOutput("midrst_fetched", perf_fetched, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Fetch resumes from RESET_PC.
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("resume_pc0",    out_pc,    32'h0);
    checkOutput("resume_instr0", out_instr, 32'h0);
    checkOutput("resume_hi",     hiPc,      32'hFFFF_FFF8);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("resume_pc1",    out_pc,    32'h4);
    checkOutput("resume_instr1", out_instr, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
